vending_machine_multi: RTL and testbench

//  Parametrised multi-product vending controller; successor to the single-product, fixed-price machine.

---
 rtl/vending_machine_multi_pkg.sv | 15 +
 rtl/vending_machine_multi_change_dispenser.sv | 32 +++
 rtl/vending_machine_multi.sv | 177 +++++++++++++++++
 tb/tb_vending_machine_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_machine_multi_pkg.sv
// Shared state encoding and coin values (in 10-yen units) for the multi-product vending controller.
package vending_machine_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam int COIN_10_VAL  = 1;
  localparam int COIN_50_VAL  = 5;
  localparam int COIN_100_VAL = 10;

endpackage

// File: rtl/vending_machine_multi_change_dispenser.sv
// Greedy change picker: one coin pulse and its value for the given credit.
// Purely combinational, zero latency; no backpressure (caller gates it by state).
module vending_machine_multi_change_dispenser
  import vending_machine_multi_pkg::*;
#(
  parameter int CRED_W = 8
) (
  input  logic [CRED_W-1:0] credit_i,
  output logic              chg10_o,
  output logic              chg50_o,
  output logic              chga0_o,
  output logic [CRED_W-1:0] amt_o
);

  always_comb begin
    chg10_o = 1'b0;
    chg50_o = 1'b0;
    chga0_o = 1'b0;
    amt_o   = '0;
    if (credit_i >= CRED_W'(COIN_100_VAL)) begin
      chga0_o = 1'b1;
      amt_o   = CRED_W'(COIN_100_VAL);
    end else if (credit_i >= CRED_W'(COIN_50_VAL)) begin
      chg50_o = 1'b1;
      amt_o   = CRED_W'(COIN_50_VAL);
    end else if (credit_i != '0) begin
      chg10_o = 1'b1;
      amt_o   = CRED_W'(COIN_10_VAL);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin crediting, per-product stock, greedy serial change.
// Coin/select act one cycle after sampling; no backpressure, coins arriving while busy are rejected.
module vending_machine_multi
  import vending_machine_multi_pkg::*;
#(
  parameter int                         N_PROD     = 4,
  parameter int                         CRED_W     = 8,
  parameter int                         MAX_CREDIT = 50,
  parameter logic [N_PROD*CRED_W-1:0]   PRICES     = {8'd15, 8'd12, 8'd10, 8'd8},
  parameter int                         STK_W      = 4,
  parameter int                         STOCK_INIT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              input10,
  input  logic              input50,
  input  logic              inputa0,
  input  logic              cancel,
  input  logic [N_PROD-1:0] sel,
  output logic [CRED_W-1:0] credit,
  output logic              vend,
  output logic [2:0]        vend_id,
  output logic              deny,
  output logic              coin_rej,
  output logic              chg10,
  output logic              chg50,
  output logic              chga0,
  output logic [N_PROD-1:0] sold_out
);

  state_t            state_q, state_d;
  logic [CRED_W-1:0] credit_q, credit_d;
  logic [STK_W-1:0]  stock_q [N_PROD];
  logic [STK_W-1:0]  stock_d [N_PROD];
  logic              in10_q, in50_q, ina0_q;
  logic [2:0]        vid_q, vid_d;
  logic              deny_q, deny_d, rej_q, rej_d;

  logic              rise10, rise50, risea0, any_coin, multi_coin, coin_ok;
  logic [CRED_W-1:0] coin_val, sel_price, vend_price, chg_amt;
  logic [CRED_W:0]   coin_sum;
  logic              sel_hit, sel_in_stock;
  logic [2:0]        sel_idx;
  logic              d10, d50, da0;

  assign rise10     = input10 & ~in10_q;
  assign rise50     = input50 & ~in50_q;
  assign risea0     = inputa0 & ~ina0_q;
  assign any_coin   = rise10 | rise50 | risea0;
  assign multi_coin = (rise10 & rise50) | (rise10 & risea0) | (rise50 & risea0);

  always_comb begin
    coin_val = '0;
    if (risea0)      coin_val = CRED_W'(COIN_100_VAL);
    else if (rise50) coin_val = CRED_W'(COIN_50_VAL);
    else if (rise10) coin_val = CRED_W'(COIN_10_VAL);
  end

  // Extra bit keeps the ceiling compare honest even when credit is near the top of its range.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok  = ((state_q == ST_IDLE) || (state_q == ST_CREDIT)) &&
                    (coin_sum <= (CRED_W+1)'(MAX_CREDIT));

  always_comb begin
    sel_hit      = 1'b0;
    sel_idx      = '0;
    sel_price    = '0;
    sel_in_stock = 1'b0;
    vend_price   = '0;
    for (int i = N_PROD-1; i >= 0; i--) begin
      if (sel[i]) begin
        sel_hit = 1'b1;
        sel_idx = 3'(i);
      end
    end
    for (int i = 0; i < N_PROD; i++) begin
      if (sel_idx == 3'(i)) begin
        sel_price    = PRICES[i*CRED_W +: CRED_W];
        sel_in_stock = (stock_q[i] != '0);
      end
      if (vid_q == 3'(i)) vend_price = PRICES[i*CRED_W +: CRED_W];
    end
  end

  vending_machine_multi_change_dispenser #(.CRED_W(CRED_W)) u_change (
    .credit_i (credit_q),
    .chg10_o  (d10),
    .chg50_o  (d50),
    .chga0_o  (da0),
    .amt_o    (chg_amt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      vid_q    <= '0;
      deny_q   <= 1'b0;
      rej_q    <= 1'b0;
      in10_q   <= 1'b0;
      in50_q   <= 1'b0;
      ina0_q   <= 1'b0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= STK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vid_q    <= vid_d;
      deny_q   <= deny_d;
      rej_q    <= rej_d;
      in10_q   <= input10;
      in50_q   <= input50;
      ina0_q   <= inputa0;
      for (int i = 0; i < N_PROD; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vid_d    = vid_q;
    deny_d   = 1'b0;
    rej_d    = multi_coin | (any_coin & ~coin_ok);
    stock_d  = stock_q;
    case (state_q)
      ST_IDLE: begin
        if (any_coin && coin_ok) begin
          credit_d = credit_q + coin_val;
          state_d  = ST_CREDIT;
        end else if (init && !any_coin) begin
          for (int i = 0; i < N_PROD; i++) stock_d[i] = STK_W'(STOCK_INIT);
        end
      end
      ST_CREDIT: begin
        if (any_coin && coin_ok) credit_d = credit_q + coin_val;
        // Selection is judged on the pre-coin credit; cancel outranks it.
        if (cancel) begin
          state_d = ST_CHANGE;
        end else if (sel_hit) begin
          if ((credit_q >= sel_price) && sel_in_stock) begin
            state_d = ST_VEND;
            vid_d   = sel_idx;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        credit_d = credit_q - vend_price;
        for (int i = 0; i < N_PROD; i++) begin
          if (vid_q == 3'(i)) stock_d[i] = stock_q[i] - STK_W'(1);
        end
        state_d = (credit_q != vend_price) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        credit_d = credit_q - chg_amt;
        if (credit_q == chg_amt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign credit   = credit_q;
  assign vend     = (state_q == ST_VEND);
  assign vend_id  = vend ? vid_q : 3'd0;
  assign deny     = deny_q;
  assign coin_rej = rej_q;
  assign chg10    = d10 & (state_q == ST_CHANGE);
  assign chg50    = d50 & (state_q == ST_CHANGE);
  assign chga0    = da0 & (state_q == ST_CHANGE);

  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock_q[i] == '0);
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi; pulse outputs are matched against a queue of expected events.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst, init, input10, input50, inputa0, cancel;
  logic [3:0] sel;
  logic [7:0] credit;
  logic       vend, deny, coin_rej, chg10, chg50, chga0;
  logic [2:0] vend_id;
  logic [3:0] sold_out;

  always #5 clk = ~clk;

  vending_machine_multi dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .input10  (input10),
    .input50  (input50),
    .inputa0  (inputa0),
    .cancel   (cancel),
    .sel      (sel),
    .credit   (credit),
    .vend     (vend),
    .vend_id  (vend_id),
    .deny     (deny),
    .coin_rej (coin_rej),
    .chg10    (chg10),
    .chg50    (chg50),
    .chga0    (chga0),
    .sold_out (sold_out)
  );

  // Pulse vector order: {vend, deny, coin_rej, chg10, chg50, chga0}
  localparam logic [5:0] P_V   = 6'b100000;
  localparam logic [5:0] P_D   = 6'b010000;
  localparam logic [5:0] P_R   = 6'b001000;
  localparam logic [5:0] P_C10 = 6'b000100;
  localparam logic [5:0] P_C50 = 6'b000010;
  localparam logic [5:0] P_CA0 = 6'b000001;

  typedef struct packed {
    logic [5:0] p;
    logic [2:0] id;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  mon_en   = 1'b0;

  function automatic void push(input logic [5:0] p, input logic [2:0] id);
    ev_t e;
    e.p  = p;
    e.id = id;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    logic [5:0] obs;
    ev_t        e;
    obs = {vend, deny, coin_rej, chg10, chg50, chga0};
    if (mon_en && (obs != 6'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got pulses=%b id=%0d expected none", obs, vend_id);
      end else begin
        e = exp_q.pop_front();
        if ((obs !== e.p) || (vend_id !== e.id)) begin
          failures++;
          $display("FAIL pulse_event got pulses=%b id=%0d expected pulses=%b id=%0d",
                   obs, vend_id, e.p, e.id);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input int v);
    if (v == 1)      input10 = 1'b1;
    else if (v == 5) input50 = 1'b1;
    else             inputa0 = 1'b1;
    tick(1);
    input10 = 1'b0;
    input50 = 1'b0;
    inputa0 = 1'b0;
    tick(1);
  endtask

  task automatic press(input logic [3:0] s);
    sel = s;
    tick(1);
    sel = '0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init = 1'b0; input10 = 1'b0; input50 = 1'b0; inputa0 = 1'b0;
    cancel = 1'b0; sel = '0;
    tick(3);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_credit", int'(credit), 0);
    chk("reset_sold_out", int'(sold_out), 0);
    chk("reset_stock0", int'(dut.stock_q[0]), 5);

    // 10+50+50 then product 0 (price 8): vend, 3 x chg10
    coin(1); coin(5); coin(5);
    chk("t1_credit", int'(credit), 11);
    push(P_V, 3'd0);
    repeat (3) push(P_C10, 3'd0);
    press(4'b0001);
    tick(1);
    chk("t1_after_vend", int'(credit), 3);
    tick(3);
    chk("t1_refunded", int'(credit), 0);
    chk("t1_stock0", int'(dut.stock_q[0]), 4);

    // 100 short of 150: deny, then top up with 50 and vend exact
    coin(10);
    chk("t2_credit", int'(credit), 10);
    push(P_D, 3'd0);
    press(4'b1000);
    chk("t2_after_deny", int'(credit), 10);
    coin(5);
    chk("t2_topup", int'(credit), 15);
    push(P_V, 3'd3);
    press(4'b1000);
    tick(1);
    chk("t2_after_vend", int'(credit), 0);
    chk("t2_stock3", int'(dut.stock_q[3]), 4);

    // 100+10 cancelled: chga0 then chg10
    coin(10); coin(1);
    chk("t3_credit", int'(credit), 11);
    push(P_CA0, 3'd0);
    push(P_C10, 3'd0);
    do_cancel();
    tick(2);
    chk("t3_refunded", int'(credit), 0);

    // Credit ceiling, then a coin during refund
    repeat (5) coin(10);
    chk("t4_at_max", int'(credit), 50);
    push(P_R, 3'd0);
    coin(10);
    chk("t4_over_max", int'(credit), 50);
    push(P_CA0, 3'd0);
    push(P_CA0 | P_R, 3'd0);
    repeat (3) push(P_CA0, 3'd0);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    inputa0 = 1'b1;
    tick(1);
    inputa0 = 1'b0;
    tick(4);
    chk("t4_refunded", int'(credit), 0);

    // Sell out product 1 (price 10), then deny, refund and restock
    for (int k = 0; k < 5; k++) begin
      coin(10);
      push(P_V, 3'd1);
      press(4'b0010);
      tick(1);
      chk("t5_exact_pay", int'(credit), 0);
    end
    chk("t5_stock1", int'(dut.stock_q[1]), 0);
    chk("t5_sold_out", int'(sold_out), 2);
    coin(10);
    push(P_D, 3'd0);
    press(4'b0010);
    chk("t5_deny_credit", int'(credit), 10);
    push(P_CA0, 3'd0);
    do_cancel();
    tick(1);
    chk("t5_refunded", int'(credit), 0);
    init = 1'b1;
    tick(1);
    init = 1'b0;
    chk("t5_init_sold_out", int'(sold_out), 0);
    chk("t5_init_stock1", int'(dut.stock_q[1]), 5);

    // Reset while refunding credit 7
    coin(5); coin(1); coin(1);
    chk("t6_credit", int'(credit), 7);
    push(P_C50, 3'd0);
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_credit_cleared", int'(credit), 0);
    tick(3);
    chk("t6_credit_stays", int'(credit), 0);
    chk("t6_stock0", int'(dut.stock_q[0]), 5);
    chk("t6_stock3", int'(dut.stock_q[3]), 5);

    // Simultaneous 10+50: 50 taken, 10 rejected; select in IDLE ignored
    input10 = 1'b1;
    input50 = 1'b1;
    push(P_R, 3'd0);
    tick(1);
    input10 = 1'b0;
    input50 = 1'b0;
    tick(1);
    chk("t7_multi_coin", int'(credit), 5);
    push(P_C50, 3'd0);
    do_cancel();
    tick(1);
    chk("t7_refunded", int'(credit), 0);
    press(4'b0001);
    tick(2);
    chk("t7_idle_sel", int'(credit), 0);

    tick(2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
